// File: rtl/conv_subblock_reader.sv
// Drains the d0/d1/d2 subblock FIFOs in lockstep and emits one {d2,d1,d0} symbol per coded bit.
// Optional statistics outputs (blk_count, stall_cycles) are enabled with SUBBLOCK_READER_STATS_EN.
module conv_subblock_reader #(
    parameter int K_SHORT = 40,
    parameter int K_LONG  = 6144,
    parameter int CNT_W   = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       computation_done,
    input  logic       code_block_length,
    input  logic       empty0,
    input  logic       empty1,
    input  logic       empty2,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    output logic       rdreq_subblock,
    output logic [2:0] sym,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       sym_last,
    output logic       block_done,
    output logic       busy
`ifdef SUBBLOCK_READER_STATS_EN
    ,
    output logic [15:0] blk_count,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       r_idx;
    logic [7:0]       r_sr0;
    logic [7:0]       r_sr1;
    logic [7:0]       r_sr2;
    logic             w_any_empty;
    logic             w_accept;
    logic             w_start;

    assign w_any_empty = empty0 | empty1 | empty2;
    assign w_accept    = (r_state == S_SHIFT) && sym_ready;
    assign w_start     = (r_state == S_IDLE) && computation_done;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (computation_done) w_next = S_FETCH;
            S_FETCH: if (!w_any_empty)     w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: begin
                // The block length is a multiple of 8, so completion can only occur on a byte boundary.
                if (w_accept && (r_idx == 3'd0)) begin
                    w_next = (w_cnt_inc == r_k) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_k   <= code_block_length ? CNT_W'(K_LONG) : CNT_W'(K_SHORT);
                r_cnt <= '0;
            end
            if (r_state == S_LOAD) begin
                r_idx <= 3'd7;
            end else if (w_accept) begin
                r_cnt <= w_cnt_inc;
                r_idx <= r_idx - 3'd1;
            end
        end
    end

    // NOTE: the shift registers are pure datapath and are not reset; sym is gated by state instead.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            r_sr0 <= q0;
            r_sr1 <= q1;
            r_sr2 <= q2;
        end
    end

    always_comb begin
        rdreq_subblock = (r_state == S_FETCH) && !w_any_empty;
        sym_valid      = (r_state == S_SHIFT);
        sym            = sym_valid ? {r_sr2[r_idx], r_sr1[r_idx], r_sr0[r_idx]} : 3'd0;
        sym_last       = sym_valid && (r_cnt == (r_k - CNT_W'(1)));
        block_done     = (r_state == S_DONE);
        busy           = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_SHIFT);
    end

`ifdef SUBBLOCK_READER_STATS_EN
    logic [15:0] r_blk_count;
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_state == S_DONE) begin
                r_blk_count <= r_blk_count + 16'd1;
            end
            // Stall counter restarts with each block and saturates rather than wrapping.
            if (w_start) begin
                r_stall_cycles <= '0;
            end else if ((r_state == S_FETCH) && w_any_empty && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign blk_count    = r_blk_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule
